// File: rtl/knight_pkg.sv
// Shared types and constants for the knight's tour checker.
// Holds the checker state enum, error classes, the knight move table and the default board size.
// Combinational definitions only; no latency or flow-control behaviour lives here.
package knight_pkg;

  localparam int DIM_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_OFF_BOARD    = 3'd1,
    ERR_ILLEGAL_MOVE = 3'd2,
    ERR_REVISIT      = 3'd3,
    ERR_NOT_CLOSED   = 3'd4
  } err_e;

  // The eight (dx, dy) displacements a knight can make, at 6-bit signed width
  // so differences of 5-bit coordinates never wrap.
  localparam int NUM_MOVES = 8;
  localparam logic signed [5:0] MOVE_DX [NUM_MOVES] =
    '{6'sd1, 6'sd2, 6'sd2, 6'sd1, -6'sd1, -6'sd2, -6'sd2, -6'sd1};
  localparam logic signed [5:0] MOVE_DY [NUM_MOVES] =
    '{6'sd2, 6'sd1, -6'sd1, -6'sd2, -6'sd2, -6'sd1, 6'sd1, 6'sd2};

endpackage

// File: rtl/knight_move_check.sv
// Purpose: flags whether square b is one knight move away from square a.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module knight_move_check (
  input  logic [4:0] a_x,
  input  logic [4:0] a_y,
  input  logic [4:0] b_x,
  input  logic [4:0] b_y,
  output logic       legal
);
  import knight_pkg::*;

  logic signed [5:0] dx;
  logic signed [5:0] dy;

  // Signed displacement from a to b, matched against the move table
  always_comb begin
    dx    = $signed({1'b0, b_x}) - $signed({1'b0, a_x});
    dy    = $signed({1'b0, b_y}) - $signed({1'b0, a_y});
    legal = 1'b0;
    for (int i = 0; i < NUM_MOVES; i++) begin
      if ((dx == MOVE_DX[i]) && (dy == MOVE_DY[i])) begin
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/knight_tour_checker.sv
// Purpose: checks a streamed sequence of squares is a knight's tour of a DIM x DIM board
//   (define KNIGHT_CLOSED_TOUR_EN to also require the last square to attack the first).
// Latency: verdict (done/pass/err_code/err_step) visible the cycle after the deciding square is accepted.
// Backpressure: in_ready is high only while running and start is low; PASS/FAIL stall input until start.
module knight_tour_checker #(
  parameter int DIM = knight_pkg::DIM_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_x,
  input  logic [4:0] in_y,
  output logic [6:0] step_cnt,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_code,
  output logic [6:0] err_step
);
  import knight_pkg::*;

  localparam logic [6:0] NSQ7 = 7'(DIM * DIM);
  localparam logic [4:0] DIM5 = 5'(DIM);
  localparam logic [5:0] DIM6 = 6'(DIM);

  state_e      state_q,    state_d;
  logic [63:0] visited_q,  visited_d;   // sized for the largest board; upper bits stay 0 on small boards
  logic [6:0]  step_cnt_q, step_cnt_d;
  logic [4:0]  prev_x_q,   prev_x_d;
  logic [4:0]  prev_y_q,   prev_y_d;
  err_e        err_code_q, err_code_d;
  logic [6:0]  err_step_q, err_step_d;

  logic       accept;
  logic       off_board;
  logic       first_step;
  logic       move_legal;
  logic       closes_ok;
  logic [5:0] sq_idx;
  logic [6:0] step_nxt;

  assign in_ready   = (state_q == ST_RUN) && !start;
  assign accept     = in_valid && in_ready;
  assign off_board  = (in_x >= DIM5) || (in_y >= DIM5);
  assign first_step = (step_cnt_q == 7'd0);
  assign step_nxt   = step_cnt_q + 7'd1;
  // Only meaningful for on-board squares, where it is always below DIM*DIM.
  assign sq_idx     = DIM6 * {1'b0, in_x} + {1'b0, in_y};

  knight_move_check u_move_check (
    .a_x   (prev_x_q),
    .a_y   (prev_y_q),
    .b_x   (in_x),
    .b_y   (in_y),
    .legal (move_legal)
  );

`ifdef KNIGHT_CLOSED_TOUR_EN
  logic [4:0] first_x_q, first_x_d;
  logic [4:0] first_y_q, first_y_d;

  // Remember where the tour started so the last square can be checked against it
  always_comb begin
    first_x_d = first_x_q;
    first_y_d = first_y_q;
    if (accept && first_step) begin
      first_x_d = in_x;
      first_y_d = in_y;
    end
  end

  // Starting-square registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_x_q <= 5'd0;
      first_y_q <= 5'd0;
    end else begin
      first_x_q <= first_x_d;
      first_y_q <= first_y_d;
    end
  end

  knight_move_check u_close_check (
    .a_x   (first_x_q),
    .a_y   (first_y_q),
    .b_x   (in_x),
    .b_y   (in_y),
    .legal (closes_ok)
  );
`else
  assign closes_ok = 1'b1;
`endif

  // Next-state: start clears everything; each accept scores the square, first error wins
  always_comb begin
    state_d    = state_q;
    visited_d  = visited_q;
    step_cnt_d = step_cnt_q;
    prev_x_d   = prev_x_q;
    prev_y_d   = prev_y_q;
    err_code_d = err_code_q;
    err_step_d = err_step_q;

    if (start) begin
      state_d    = ST_RUN;
      visited_d  = '0;
      step_cnt_d = 7'd0;
      err_code_d = ERR_NONE;
      err_step_d = 7'd0;
    end else if (accept) begin
      step_cnt_d = step_nxt;
      prev_x_d   = in_x;
      prev_y_d   = in_y;
      if (!off_board) begin
        visited_d[sq_idx] = 1'b1;
      end

      if (off_board) begin
        state_d    = ST_FAIL;
        err_code_d = ERR_OFF_BOARD;
        err_step_d = step_nxt;
      end else if (!first_step && !move_legal) begin
        state_d    = ST_FAIL;
        err_code_d = ERR_ILLEGAL_MOVE;
        err_step_d = step_nxt;
      end else if (visited_q[sq_idx]) begin
        state_d    = ST_FAIL;
        err_code_d = ERR_REVISIT;
        err_step_d = step_nxt;
      end else if (step_nxt == NSQ7) begin
        if (!closes_ok) begin
          state_d    = ST_FAIL;
          err_code_d = ERR_NOT_CLOSED;
          err_step_d = step_nxt;
        end else begin
          state_d = ST_PASS;
        end
      end
    end
  end

  // Checker state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      visited_q  <= '0;
      step_cnt_q <= 7'd0;
      prev_x_q   <= 5'd0;
      prev_y_q   <= 5'd0;
      err_code_q <= ERR_NONE;
      err_step_q <= 7'd0;
    end else begin
      state_q    <= state_d;
      visited_q  <= visited_d;
      step_cnt_q <= step_cnt_d;
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      err_code_q <= err_code_d;
      err_step_q <= err_step_d;
    end
  end

  assign step_cnt = step_cnt_q;
  assign done     = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass     = (state_q == ST_PASS);
  assign err_code = err_code_q;
  assign err_step = err_step_q;

endmodule

// File: doc/knight_tour_checker.md
KNIGHT_TOUR_CHECKER -- requirements
Module: knight_tour_checker

Interface
REQ-001 Parameter: DIM, default 5, board edge length (legal range 5..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse: clear the board and begin checking a new tour.
REQ-005 in_valid  input  1  a square coordinate is presented on in_x/in_y.
REQ-006 in_ready  output  1  checker accepts a square this cycle.
REQ-007 in_x  input  5  row of the square (unsigned).
REQ-008 in_y  input  5  column of the square (unsigned).
REQ-009 step_cnt  output  7  number of squares accepted so far.
REQ-010 done  output  1  check finished, either pass or error; held until start or rst.
REQ-011 pass  output  1  valid tour; meaningful only while done=1.
REQ-012 err_code  output  3  error class: 0 none, 1 off-board, 2 illegal move, 3 revisit, 4 not closed.
REQ-013 err_step  output  7  step number (1-based) of the offending square.

Function
REQ-014 The checker SHALL use the states IDLE, RUN, PASS and FAIL, and SHALL be in IDLE after reset.
REQ-015 start SHALL, from any state, clear the visited bitmap (DIM*DIM bits), step_cnt, done, pass, err_code and err_step, and SHALL enter RUN on the next edge.
REQ-016 in_ready SHALL be 1 only in RUN with start=0, and a square is accepted when in_valid and in_ready are both 1.
REQ-017 If start and in_valid are asserted together, start SHALL win and no square SHALL be accepted.
REQ-018 On each accept, step_cnt SHALL increment and the square SHALL be marked visited at bit index DIM*in_x+in_y.
REQ-019 Off-board check: if in_x>=DIM or in_y>=DIM, the state SHALL go to FAIL with err_code=1.
REQ-020 Move check, every accept after the first: if (|dx|,|dy|) relative to the previous square is not (1,2) or (2,1), the state SHALL go to FAIL with err_code=2.
REQ-021 Revisit check: if the square is already marked visited, the state SHALL go to FAIL with err_code=3.
REQ-022 Priority when several errors hit the same square: 1 over 2 over 3.
REQ-023 When the accept with step_cnt reaching DIM*DIM has no error, the state SHALL go to PASS.
REQ-024 Latency: done SHALL rise on the edge that accepts the final or failing square, i.e. done is visible in the next cycle.
REQ-025 On FAIL, err_step SHALL equal the post-increment step_cnt of the failing square.
REQ-026 In PASS and FAIL, in_ready SHALL be 0 and inputs SHALL be ignored.
REQ-027 pass SHALL be 1 only in PASS, and done SHALL be 1 in both PASS and FAIL.
REQ-028 Coordinate differences SHALL be computed at 6-bit signed width, so there is no wrap-around.

Reset
REQ-029 rst SHALL force IDLE, clear the bitmap and set every output to 0, including in_ready.
REQ-030 rst asserted mid-tour SHALL abandon the tour, and only a subsequent start SHALL resume checking.

Configuration
REQ-031 With KNIGHT_CLOSED_TOUR_EN defined, the final square SHALL additionally be a knight move from the first square.
REQ-032 Under KNIGHT_CLOSED_TOUR_EN, a final square that is not a knight move from the first square SHALL give FAIL with err_code=4 and err_step=DIM*DIM; without the macro, err_code 4 SHALL never occur and the first-square register SHALL be omitted.

Structure
REQ-033 Package knight_pkg SHALL hold the state enum, the err_code enum, the 8-entry knight move offset table and the default DIM.
REQ-034 Legal-move detection SHALL be one combinational sub-module, knight_move_check: inputs are two coordinate pairs, output is legal.

Verification
REQ-035 Valid case: start, then a 25-square valid open tour from (0,0) on DIM=5, with in_valid held high -> done=1 and pass=1 one cycle after the 25th accept, step_cnt=25.
REQ-036 Illegal move: squares (0,0),(1,1) -> done=1, pass=0, err_code=2, err_step=2.
REQ-037 Revisit: squares (0,0),(2,1),(0,0) -> err_code=3, err_step=3.
REQ-038 Off-board: squares (0,0),(5,1) -> err_code=1, err_step=2, and in_ready=0 afterward.
REQ-039 Reset and restart: assert rst after 10 accepts -> all outputs 0; then start with in_valid=1 in the same cycle -> no accept that cycle, and a fresh tour passes.
REQ-040 Closed-tour build (KNIGHT_CLOSED_TOUR_EN defined): a valid open tour that ends on a non-attacking square -> err_code=4, err_step=25.
